// File: rtl/spi_slave_cmd_ctrl.sv
// Command sequencer between the SPI word deserializer and the SPI-to-AXI plug.
// Define SPI_SLAVE_CMD_ADDR_ALIGN_EN to force rxtx_addr[1:0] to 2'b00 on load.
module spi_slave_cmd_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter logic [15:0] WRAP_RESET     = 16'h0000,
    parameter logic [7:0]  DUMMY_RESET    = 8'd32
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      cs,
    input  logic [31:0]               spi_word,
    input  logic                      spi_word_valid,
    output logic [AXI_ADDR_WIDTH-1:0] rxtx_addr,
    output logic                      rxtx_addr_valid,
    output logic                      start_tx,
    output logic [15:0]               wrap_length,
    output logic [7:0]                dummy_cycles,
    output logic [31:0]               rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      wr_overflow
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_WR_DATA, ST_RD_ACTIVE, ST_CFG_WRAP, ST_CFG_DUMMY, ST_IGNORE
    } state_e;

    state_e                    state_q, state_d;
    logic                      is_read_q, is_read_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d, addr_word, addr_load;
    logic                      addr_valid_q, addr_valid_d;
    logic                      start_q, start_d;
    logic [15:0]               wrap_q, wrap_d;
    logic [7:0]                dummy_q, dummy_d;
    logic                      ovf_q, ovf_d;
    logic [31:0]               mem_q [2];
    logic [31:0]               mem_d [2];
    logic                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic                      word_v, push_req, push, pop, full;

    if (AXI_ADDR_WIDTH <= 32) begin : g_addr_trunc
        assign addr_word = spi_word[AXI_ADDR_WIDTH-1:0];
    end else begin : g_addr_ext
        assign addr_word = {{(AXI_ADDR_WIDTH-32){1'b0}}, spi_word};
    end

    always_comb begin
        addr_load = addr_word;
`ifdef SPI_SLAVE_CMD_ADDR_ALIGN_EN
        addr_load[1:0] = 2'b00;
`endif
    end

    // Deselect masks the word strobe, so cs wins over a same-cycle word everywhere.
    assign word_v   = spi_word_valid & ~cs;
    assign push_req = (state_q == ST_WR_DATA) & word_v;
    assign full     = (count_q == 2'd2);
    assign pop      = rx_valid & rx_ready;
    assign push     = push_req & (~full | pop);

    always_comb begin
        state_d      = state_q;
        is_read_d    = is_read_q;
        addr_d       = addr_q;
        addr_valid_d = 1'b0;
        start_d      = 1'b0;
        wrap_d       = wrap_q;
        dummy_d      = dummy_q;
        ovf_d        = ovf_q;
        if (state_q != ST_IDLE && cs) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (!cs) state_d = ST_CMD;
                ST_CMD: if (word_v) begin
                    ovf_d = 1'b0;
                    unique case (spi_word[7:0])
                        8'h02: begin state_d = ST_ADDR; is_read_d = 1'b0; end
                        8'h0B: begin state_d = ST_ADDR; is_read_d = 1'b1; end
                        8'h11: state_d = ST_CFG_WRAP;
                        8'h71: state_d = ST_CFG_DUMMY;
                        default: state_d = ST_IGNORE;
                    endcase
                end
                ST_ADDR: if (word_v) begin
                    addr_d       = addr_load;
                    addr_valid_d = 1'b1;
                    start_d      = is_read_q;
                    state_d      = is_read_q ? ST_RD_ACTIVE : ST_WR_DATA;
                end
                ST_CFG_WRAP: if (word_v) begin
                    wrap_d  = spi_word[15:0];
                    state_d = ST_IGNORE;
                end
                ST_CFG_DUMMY: if (word_v) begin
                    dummy_d = spi_word[7:0];
                    state_d = ST_IGNORE;
                end
                default: ;
            endcase
        end
        if (push_req && !push) ovf_d = 1'b1;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop) rd_ptr_d = ~rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = spi_word;
            wr_ptr_d        = ~wr_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= ST_IDLE;
            is_read_q    <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            start_q      <= 1'b0;
            wrap_q       <= WRAP_RESET;
            dummy_q      <= DUMMY_RESET;
            ovf_q        <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            is_read_q    <= is_read_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            start_q      <= start_d;
            wrap_q       <= wrap_d;
            dummy_q      <= dummy_d;
            ovf_q        <= ovf_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign rxtx_addr       = addr_q;
    assign rxtx_addr_valid = addr_valid_q;
    assign start_tx        = start_q;
    assign wrap_length     = wrap_q;
    assign dummy_cycles    = dummy_q;
    assign rx_valid        = (count_q != 2'd0);
    assign rx_data         = mem_q[rd_ptr_q];
    assign wr_overflow     = ovf_q;

endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// Self-checking bench for spi_slave_cmd_ctrl: directed vector table, corner sequences,
// and random frames checked against a word-index frame model.
module tb_spi_slave_cmd_ctrl;

    localparam int          AW        = 32;
    localparam logic [15:0] WRAP_RST  = 16'h0000;
    localparam logic [7:0]  DUMMY_RST = 8'd32;

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn = 1'b0;
    logic          cs = 1'b1;
    logic [31:0]   spi_word = '0;
    logic          spi_word_valid = 1'b0;
    logic          rx_ready = 1'b0;
    logic [AW-1:0] rxtx_addr;
    logic          rxtx_addr_valid, start_tx, rx_valid, wr_overflow;
    logic [15:0]   wrap_length;
    logic [7:0]    dummy_cycles;
    logic [31:0]   rx_data;

    always #5 axi_aclk = ~axi_aclk;

    spi_slave_cmd_ctrl #(
        .AXI_ADDR_WIDTH(AW),
        .WRAP_RESET    (WRAP_RST),
        .DUMMY_RESET   (DUMMY_RST)
    ) dut (
        .axi_aclk       (axi_aclk),
        .axi_aresetn    (axi_aresetn),
        .cs             (cs),
        .spi_word       (spi_word),
        .spi_word_valid (spi_word_valid),
        .rxtx_addr      (rxtx_addr),
        .rxtx_addr_valid(rxtx_addr_valid),
        .start_tx       (start_tx),
        .wrap_length    (wrap_length),
        .dummy_cycles   (dummy_cycles),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .wr_overflow    (wr_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: counts accepted words per chip-select frame and acts on the word index.
    bit            m_frame;
    int            m_idx;
    logic [7:0]    m_op;
    logic [31:0]   m_q[$];
    logic [AW-1:0] m_addr;
    bit            m_av, m_st, m_ovf;
    logic [15:0]   m_wrap;
    logic [7:0]    m_dummy;

    function automatic void model_reset();
        m_frame = 0; m_idx = 0; m_op = '0; m_q.delete();
        m_addr = '0; m_av = 0; m_st = 0; m_ovf = 0;
        m_wrap = WRAP_RST; m_dummy = DUMMY_RST;
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [31:0] w);
        logic [AW-1:0] a;
        a = w[AW-1:0];
`ifdef SPI_SLAVE_CMD_ADDR_ALIGN_EN
        a[1:0] = 2'b00;
`endif
        return a;
    endfunction

    function automatic void model_step();
        bit word, pop;
        word = spi_word_valid && !cs && m_frame;
        pop  = (m_q.size() > 0) && rx_ready;
        m_av = 0; m_st = 0;
        if (pop) void'(m_q.pop_front());
        if (word) begin
            if (m_idx == 0) begin
                m_op = spi_word[7:0]; m_ovf = 0;
            end else if (m_idx == 1) begin
                case (m_op)
                    8'h02, 8'h0B: begin
                        m_addr = addr_of(spi_word); m_av = 1; m_st = (m_op == 8'h0B);
                    end
                    8'h11: m_wrap = spi_word[15:0];
                    8'h71: m_dummy = spi_word[7:0];
                    default: ;
                endcase
            end else if (m_op == 8'h02) begin
                if (m_q.size() < 2) m_q.push_back(spi_word);
                else m_ovf = 1;
            end
            m_idx++;
        end
        m_frame = !cs;
        if (cs) m_idx = 0;
    endfunction

    task automatic compare_all();
        chk("rxtx_addr", rxtx_addr, m_addr);
        chk("rxtx_addr_valid", rxtx_addr_valid, m_av);
        chk("start_tx", start_tx, m_st);
        chk("wrap_length", wrap_length, m_wrap);
        chk("dummy_cycles", dummy_cycles, m_dummy);
        chk("rx_valid", rx_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("rx_data", rx_data, m_q[0]);
        chk("wr_overflow", wr_overflow, m_ovf);
    endtask

    task automatic cycle();
        model_step();
        @(posedge axi_aclk);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [31:0] w);
        spi_word = w; spi_word_valid = 1'b1;
        cycle();
        spi_word_valid = 1'b0;
    endtask

    task automatic idle_cycle(input logic c);
        cs = c; spi_word_valid = 1'b0;
        cycle();
    endtask

    typedef struct {
        logic        cs;
        logic        vld;
        logic [31:0] word;
        logic        rdy;
        logic        av;
        logic        st;
        logic        rv;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 32'h1000_0004, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 1'b1, 32'hAAAA_5555, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAA_5555};
        tbl[4] = '{1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678};
        tbl[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

        model_reset();
        repeat (2) @(posedge axi_aclk);
        #1;
        compare_all();
        axi_aresetn = 1'b1;
        idle_cycle(1'b1);

        // Write frame from the vector table
        for (int i = 0; i < 7; i++) begin
            cs = tbl[i].cs; spi_word_valid = tbl[i].vld; spi_word = tbl[i].word; rx_ready = tbl[i].rdy;
            cycle();
            chk("tbl_addr_valid", rxtx_addr_valid, tbl[i].av);
            chk("tbl_start_tx", start_tx, tbl[i].st);
            chk("tbl_rx_valid", rx_valid, tbl[i].rv);
            if (tbl[i].rv) chk("tbl_rx_data", rx_data, tbl[i].rd);
        end
        chk("wr_frame_addr", rxtx_addr, 32'h1000_0004);

        // Read frame: strobes coincide for one cycle, trailing words ignored
        idle_cycle(1'b0);
        send(32'h0000_000B);
        send(32'h0000_0100);
        chk("rd_addr_valid", rxtx_addr_valid, 1'b1);
        chk("rd_start_tx", start_tx, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send($urandom);
            chk("rd_trail_av", rxtx_addr_valid, 1'b0);
            chk("rd_trail_st", start_tx, 1'b0);
        end
        idle_cycle(1'b1);

        // Overflow with rx_ready low, then cleared by the next command
        rx_ready = 1'b0;
        idle_cycle(1'b0);
        send(32'h0000_0002);
        send(32'h0000_0040);
        send(32'hD1D1_0001);
        send(32'hD2D2_0002);
        chk("ovf_before_third", wr_overflow, 1'b0);
        send(32'hD3D3_0003);
        chk("ovf_set", wr_overflow, 1'b1);
        chk("ovf_head", rx_data, 32'hD1D1_0001);
        idle_cycle(1'b1);
        chk("ovf_sticky", wr_overflow, 1'b1);
        idle_cycle(1'b0);
        send(32'h0000_0011);
        chk("ovf_cleared", wr_overflow, 1'b0);
        send(32'h0000_0005);
        chk("wrap_loaded", wrap_length, 16'h0005);
        idle_cycle(1'b1);
        rx_ready = 1'b1;
        idle_cycle(1'b1);
        chk("drain_second", rx_data, 32'hD2D2_0002);
        idle_cycle(1'b1);
        chk("drained", rx_valid, 1'b0);

        // Unknown opcode: nothing happens, then dummy config
        idle_cycle(1'b0);
        send(32'h0000_0099);
        for (int i = 0; i < 4; i++) begin
            send($urandom);
            chk("ign_av", rxtx_addr_valid, 1'b0);
            chk("ign_rv", rx_valid, 1'b0);
        end
        chk("ign_wrap", wrap_length, 16'h0005);
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        send(32'h0000_0071);
        send(32'h0000_0010);
        chk("dummy_16", dummy_cycles, 8'd16);
        idle_cycle(1'b1);

        // Address alignment option
        idle_cycle(1'b0);
        send(32'h0000_0002);
        send(32'h2000_0007);
`ifdef SPI_SLAVE_CMD_ADDR_ALIGN_EN
        chk("addr_align", rxtx_addr, 32'h2000_0004);
`else
        chk("addr_pass", rxtx_addr, 32'h2000_0007);
`endif
        idle_cycle(1'b1);

        // cs rises with the address word: word ignored
        idle_cycle(1'b0);
        send(32'h0000_0002);
        cs = 1'b1;
        send(32'h0000_0055);
        chk("cs_prio_av", rxtx_addr_valid, 1'b0);
        idle_cycle(1'b1);
        chk("cs_prio_av2", rxtx_addr_valid, 1'b0);

        // Asynchronous reset with two buffered words
        rx_ready = 1'b0;
        idle_cycle(1'b0);
        send(32'h0000_0002);
        send(32'h0000_0080);
        send(32'hE1E1_0001);
        send(32'hE2E2_0002);
        chk("pre_reset_rv", rx_valid, 1'b1);
        axi_aresetn = 1'b0;
        cs = 1'b1;
        #1;
        model_reset();
        chk("async_rst_rv", rx_valid, 1'b0);
        chk("async_rst_wrap", wrap_length, WRAP_RST);
        compare_all();
        @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;
        idle_cycle(1'b1);

        // Random frames
        for (int f = 0; f < 150; f++) begin
            logic [7:0] op;
            int         nw;
            case ($urandom_range(0, 4))
                0: op = 8'h02;
                1: op = 8'h0B;
                2: op = 8'h11;
                3: op = 8'h71;
                default: op = 8'($urandom);
            endcase
            nw = $urandom_range(0, 7);
            rx_ready = 1'($urandom_range(0, 1));
            idle_cycle(1'b0);
            for (int i = 0; i < nw; i++) begin
                rx_ready = 1'($urandom_range(0, 1));
                spi_word_valid = ($urandom_range(0, 3) != 0);
                spi_word = (i == 0) ? {24'($urandom), op} : $urandom;
                cycle();
            end
            cs = 1'b1;
            spi_word_valid = 1'($urandom_range(0, 1));
            spi_word = $urandom;
            rx_ready = 1'($urandom_range(0, 1));
            cycle();
            spi_word_valid = 1'b0;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
